ahb_rom_bank_ctrl: RTL and testbench

//  AHB-Lite slave front-end sequencing four 512x32 ROM macros (8 KB total) as a single program ROM.

---
 rtl/ahb_rom_bank_ctrl.sv | 131 +++++++++++++
 tb/tb_ahb_rom_bank_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rom_bank_ctrl.sv
// AHB-Lite read-only slave fronting four 512x32 ROM banks (8 KB program ROM).
// Latency: data returned 1 + WAIT_STATES cycles after the address phase; back-to-back at 1/cycle.
// Backpressure: HREADYOUT held low for WAIT_STATES cycles per read and for the first ERROR cycle.
// Ports: AHB-Lite slave side (HCLK/HRESETn, HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
//        HREADYOUT, HRESP, HRDATA); ROM side (ROM_EN one-hot bank enable, ROM_AD shared word
//        address, ROM_DO0..3 bank data, valid the cycle after the enable is sampled).
module ahb_rom_bank_ctrl #(
    parameter int unsigned WAIT_STATES  = 0,
    parameter bit          ERR_ON_WRITE = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [3:0]  ROM_EN,
    output logic [8:0]  ROM_AD,
    input  logic [31:0] ROM_DO0,
    input  logic [31:0] ROM_DO1,
    input  logic [31:0] ROM_DO2,
    input  logic [31:0] ROM_DO3
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t     state_q, state_d;
    logic [1:0] bank_q, bank_d;
    logic [2:0] wcnt_q, wcnt_d;

    logic       accept;
    logic       rd_go;
    logic       wr_err;

    // Size, write data and the untranslated address bits carry no meaning for a word ROM.
    logic unused_ok;
    assign unused_ok = ^{HSIZE, HWDATA, HADDR[31:13], HADDR[1:0], HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];
    // HREADYOUT gating keeps the enable to a single cycle even if HREADY is mis-driven
    // while this slave is stalling; on a legal bus it is redundant with HREADY.
    assign rd_go  = accept & ~HWRITE & HREADYOUT;
    assign wr_err = accept & HWRITE & ERR_ON_WRITE;

    // ROM address phase
    always_comb begin
        ROM_EN = 4'b0000;
        ROM_AD = 9'h000;
        if (accept) begin
            ROM_AD = HADDR[10:2];
        end
        if (rd_go) begin
            ROM_EN[HADDR[12:11]] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            bank_q  <= 2'd0;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: a new transfer is only taken in a cycle that completes the previous one.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        wcnt_d  = wcnt_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (state_q == ST_RD && wcnt_q != 3'd0) begin
            wcnt_d = wcnt_q - 3'd1;
        end else if (rd_go) begin
            state_d = ST_RD;
            bank_d  = HADDR[12:11];
            wcnt_d  = WS;
        end else if (wr_err) begin
            state_d = ST_ERR1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Outputs
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        case (state_q)
            ST_RD: begin
                HREADYOUT = (wcnt_q == 3'd0);
                case (bank_q)
                    2'd0:    HRDATA = ROM_DO0;
                    2'd1:    HRDATA = ROM_DO1;
                    2'd2:    HRDATA = ROM_DO2;
                    default: HRDATA = ROM_DO3;
                endcase
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_rom_bank_ctrl.sv
// Directed bench for ahb_rom_bank_ctrl: three configurations share one bus, only one selected at a time.
// Read data is checked through a scoreboard fed from a behavioural ROM bank model.
// Each instance's HREADY is its own HREADYOUT, as on a single-slave bus.
module tb_ahb_rom_bank_ctrl;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic        clk;
    logic        rst_n;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic [2:0]  hrdyo;
    logic [2:0]  hresp;
    logic [31:0] hrdata [3];
    logic [3:0]  rom_en [3];
    logic [8:0]  rom_ad [3];

    int          vectors;
    int          miscompares;
    int          act;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] rom_word(input int b, input logic [8:0] a);
        logic [31:0] bb;
        bb = b;
        return {4'hC, bb[1:0], a, 17'h1A5A5};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] do_q [4];

        ahb_rom_bank_ctrl #(
            .WAIT_STATES  (g == 0 ? 0 : (g == 1 ? 2 : 3)),
            .ERR_ON_WRITE (g == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .HCLK      (clk),
            .HRESETn   (rst_n),
            .HSEL      (hsel[g]),
            .HREADY    (hrdyo[g]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HWDATA    (hwdata),
            .HREADYOUT (hrdyo[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g]),
            .ROM_EN    (rom_en[g]),
            .ROM_AD    (rom_ad[g]),
            .ROM_DO0   (do_q[0]),
            .ROM_DO1   (do_q[1]),
            .ROM_DO2   (do_q[2]),
            .ROM_DO3   (do_q[3])
        );

        // ROM macro model: registered output on enable, held otherwise.
        always @(posedge clk) begin
            for (int b = 0; b < 4; b++) begin
                if (rom_en[g][b]) do_q[b] <= rom_word(b, rom_ad[g]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] addr);
        hsel      = 3'b000;
        hsel[act] = sel;
        htrans    = tr;
        hwrite    = wr;
        haddr     = addr;
    endtask

    // One bus cycle on the active instance: check handshake and ROM side, pop read data
    // when a read data phase completes, push expected data for a read accepted now.
    task automatic cyc(input string tag, input logic rdy, input logic resp,
                       input logic [3:0] en, input logic [8:0] ad, input bit pop);
        logic [31:0] e;
        bit          acc;
        acc = hsel[act] && htrans[1] && rdy && !hwrite;
        @(negedge clk);
        chk({tag, ".hreadyout"}, 32'(hrdyo[act]), 32'(rdy));
        chk({tag, ".hresp"},     32'(hresp[act]), 32'(resp));
        chk({tag, ".rom_en"},    32'(rom_en[act]), 32'(en));
        chk({tag, ".rom_ad"},    32'(rom_ad[act]), 32'(ad));
        if (pop) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s.sb: observed data phase with no expected entry", tag);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".hrdata"}, hrdata[act], e);
            end
        end
        if (acc) exp_q.push_back(rom_word(int'(haddr[12:11]), haddr[10:2]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        act         = 0;
        rst_n       = 1'b0;
        hsel        = 3'b000;
        haddr       = 32'h0;
        htrans      = T_IDLE;
        hwrite      = 1'b0;
        hsize       = 3'b010;
        hwdata      = 32'hFFFF_FFFF;

        // Reset state of every configuration
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d.hreadyout", i), 32'(hrdyo[i]), 32'h1);
            chk($sformatf("rst%0d.hresp", i),     32'(hresp[i]), 32'h0);
            chk($sformatf("rst%0d.hrdata", i),    hrdata[i],     32'h0);
            chk($sformatf("rst%0d.rom_en", i),    32'(rom_en[i]), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait read of 0x1008: bank 2, word 2
        act = 0;
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_1008);
        cyc("rd0_addr", 1'b1, 1'b0, 4'b0100, 9'h002, 1'b0);
        // Back-to-back zero-wait reads, first overlapping the previous data phase
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_0004);
        cyc("b2b_a", 1'b1, 1'b0, 4'b0001, 9'h001, 1'b1);
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_1804);
        cyc("b2b_b", 1'b1, 1'b0, 4'b1000, 9'h001, 1'b1);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("b2b_end", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b1);

        // Two wait states, 0x0000 then 0x1FFC back-to-back
        act = 1;
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_0000);
        cyc("ws2_a_addr", 1'b1, 1'b0, 4'b0001, 9'h000, 1'b0);
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_1FFC);
        cyc("ws2_a_w1", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("ws2_a_w2", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("ws2_b_addr", 1'b1, 1'b0, 4'b1000, 9'h1FF, 1'b1);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("ws2_b_w1", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("ws2_b_w2", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("ws2_b_done", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b1);

        // Write with ERROR response, then a read issued in the ERR2 cycle
        act = 0;
        set_bus(1'b1, T_NONSEQ, 1'b1, 32'h0000_0800);
        cyc("wr_addr", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b0);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("wr_err1", 1'b0, 1'b1, 4'b0000, 9'h000, 1'b0);
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_0808);
        cyc("wr_err2", 1'b1, 1'b1, 4'b0010, 9'h002, 1'b0);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("err_rd_data", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b1);

        // Non-transfers: BUSY while selected, NONSEQ while not selected
        set_bus(1'b1, T_BUSY, 1'b0, 32'h0000_1008);
        cyc("busy", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b0);
        set_bus(1'b0, T_NONSEQ, 1'b0, 32'h0000_1008);
        cyc("nosel", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b0);
        set_bus(1'b0, T_IDLE, 1'b0, 32'h0);
        cyc("nosel_after", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b0);

        // Reset during the second of three wait states
        act = 2;
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_0C00);
        cyc("rst_rd_addr", 1'b1, 1'b0, 4'b0010, 9'h100, 1'b0);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("rst_rd_w1", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        #1;
        chk("rst_mid_wait.hreadyout", 32'(hrdyo[2]), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_async.hreadyout", 32'(hrdyo[2]), 32'h1);
        chk("rst_async.hresp",     32'(hresp[2]), 32'h0);
        chk("rst_async.hrdata",    hrdata[2],     32'h0);
        chk("rst_async.rom_en",    32'(rom_en[2]), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_1FF8);
        cyc("post_rst_addr", 1'b1, 1'b0, 4'b1000, 9'h1FE, 1'b0);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("post_rst_w1", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("post_rst_w2", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("post_rst_w3", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("post_rst_data", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b1);

        // Writes ignored with OKAY when ERROR responses are disabled
        set_bus(1'b1, T_NONSEQ, 1'b1, 32'h0000_0400);
        cyc("okwr_addr", 1'b1, 1'b0, 4'b0000, 9'h100, 1'b0);
        set_bus(1'b1, T_NONSEQ, 1'b0, 32'h0000_1404);
        cyc("okwr_data_rd_addr", 1'b1, 1'b0, 4'b0100, 9'h101, 1'b0);
        set_bus(1'b1, T_IDLE, 1'b0, 32'h0);
        cyc("okwr_rd_w1", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("okwr_rd_w2", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("okwr_rd_w3", 1'b0, 1'b0, 4'b0000, 9'h000, 1'b0);
        cyc("okwr_rd_data", 1'b1, 1'b0, 4'b0000, 9'h000, 1'b1);

        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
